// File: rtl/uart_hex_wb_bridge_pkg.sv
// Shared constants, FSM states and ASCII/hex conversions for the UART hex Wishbone bridge.
package uart_hex_wb_bridge_pkg;

  localparam logic [7:0] CharAddr  = "a";
  localparam logic [7:0] CharData  = "d";
  localparam logic [7:0] CharCount = "c";
  localparam logic [7:0] CharRead  = "r";
  localparam logic [7:0] CharWrite = "w";
  localparam logic [7:0] CharReset = ".";
  localparam logic [7:0] CharEol   = 8'h0A;
  localparam logic [7:0] CharBang  = "!";

  typedef enum logic [1:0] {StIdle, StBus, StTxHex, StTxEol} state_e;
  typedef enum logic [1:0] {SelAddr, SelData, SelCount} sel_e;

  function automatic logic is_hex(input logic [7:0] c);
    return ((c >= "0") && (c <= "9")) || ((c >= "A") && (c <= "F"));
  endfunction

  // Digits have the value in the low nibble; 'A'..'F' have 1..6 there and bit 6 set.
  function automatic logic [3:0] hex_val(input logic [7:0] c);
    return c[3:0] + (c[6] ? 4'd9 : 4'd0);
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? {4'h3, n} : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/uart_hex_wb_bridge_tx.sv
// Serialises a word as uppercase ASCII hex (MS nibble first) or a single raw character,
// one trigger per character, honouring the transmitter busy handshake.
module hex_tx_serializer
  import uart_hex_wb_bridge_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              raw_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              abort_i,
  input  logic              tx_busy_i,
  output logic [7:0]        tx_dat_o,
  output logic              tx_trigger_o,
  output logic              done_o
);

  localparam int unsigned Nibbles = DATA_W / 4;
  localparam int unsigned IdxW    = $clog2(Nibbles + 1);

  logic [DATA_W-1:0] word_q;
  logic [IdxW-1:0]   left_q;
  logic              raw_q, active_q, gap_q;
  logic [7:0]        tx_dat_q;
  logic              trigger_q, done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      word_q    <= '0;
      left_q    <= '0;
      raw_q     <= 1'b0;
      active_q  <= 1'b0;
      gap_q     <= 1'b0;
      tx_dat_q  <= '0;
      trigger_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      trigger_q <= 1'b0;
      done_q    <= 1'b0;
      gap_q     <= 1'b0;
      if (abort_i) begin
        active_q <= 1'b0;
      end else if (start_i) begin
        word_q   <= word_i;
        raw_q    <= raw_i;
        left_q   <= raw_i ? IdxW'(1) : IdxW'(Nibbles);
        active_q <= 1'b1;
      end else if (active_q && !gap_q && !tx_busy_i) begin
        // The cycle after a trigger is skipped so the transmitter can raise busy.
        trigger_q <= 1'b1;
        tx_dat_q  <= raw_q ? word_q[7:0] : hex_char(word_q[DATA_W-1 -: 4]);
        word_q    <= word_q << 4;
        left_q    <= left_q - IdxW'(1);
        gap_q     <= 1'b1;
        if (left_q == IdxW'(1)) begin
          active_q <= 1'b0;
          done_q   <= 1'b1;
        end
      end
    end
  end

  assign tx_dat_o     = tx_dat_q;
  assign tx_trigger_o = trigger_q;
  assign done_o       = done_q;

endmodule

// File: rtl/uart_hex_wb_bridge.sv
// UART-driven Wishbone master: hex-entered ADDR/DATA/COUNT registers, single or burst
// read/write, read data echoed back as ASCII hex lines.
module uart_hex_wb_bridge
  import uart_hex_wb_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W  = 24,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              i_wb_clk,
  input  logic              i_wb_rst,
  input  logic              i_wb_ack,
  input  logic [DATA_W-1:0] i_wb_dat,
  output logic [DATA_W-1:0] o_wb_dat,
  output logic [ADDR_W-1:0] o_wb_addr,
  output logic              o_wb_stb,
  output logic              o_wb_cyc,
  output logic              o_wb_we,
  input  logic [7:0]        uart_rx_dat,
  input  logic              uart_received_strobe,
  output logic [7:0]        uart_tx_dat,
  output logic              uart_tx_trigger,
  input  logic              i_uart_tx_busy,
  output logic              o_reset,
  output logic              o_err
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

  state_e            state_q;
  sel_e              sel_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  count_q, remain_q;
  logic [15:0]       timer_q;
  logic              stb_q, we_q, reset_q, err_q, abort_q;
  logic              ser_start_q, ser_raw_q, ser_done;
  logic [DATA_W-1:0] ser_word_q;
  logic              rx_dot;
  logic [3:0]        rx_nib;

  assign rx_dot = uart_received_strobe && (uart_rx_dat == CharReset);
  assign rx_nib = hex_val(uart_rx_dat);

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state_q     <= StIdle;
      sel_q       <= SelAddr;
      addr_q      <= '0;
      data_q      <= '0;
      count_q     <= '0;
      remain_q    <= '0;
      timer_q     <= '0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      reset_q     <= 1'b0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
      ser_start_q <= 1'b0;
      ser_raw_q   <= 1'b0;
      ser_word_q  <= '0;
    end else begin
      reset_q     <= 1'b0;
      err_q       <= 1'b0;
      ser_start_q <= 1'b0;
      if (rx_dot) begin
        state_q <= StIdle;
        sel_q   <= SelAddr;
        stb_q   <= 1'b0;
        abort_q <= 1'b0;
        addr_q  <= '0;
        data_q  <= '0;
        count_q <= '0;
        reset_q <= 1'b1;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (uart_received_strobe) begin
              if (is_hex(uart_rx_dat)) begin
                unique case (sel_q)
                  SelData:  data_q  <= (data_q << 4) | DATA_W'(rx_nib);
                  SelCount: count_q <= (count_q << 4) | CNT_W'(rx_nib);
                  default:  addr_q  <= (addr_q << 4) | ADDR_W'(rx_nib);
                endcase
              end else if (uart_rx_dat == CharAddr) begin
                sel_q  <= SelAddr;
                addr_q <= '0;
              end else if (uart_rx_dat == CharData) begin
                sel_q  <= SelData;
                data_q <= '0;
              end else if (uart_rx_dat == CharCount) begin
                sel_q   <= SelCount;
                count_q <= '0;
              end else if ((uart_rx_dat == CharRead) || (uart_rx_dat == CharWrite)) begin
                state_q  <= StBus;
                we_q     <= (uart_rx_dat == CharWrite);
                remain_q <= count_q;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
          StBus: begin
            // Entering with stb low gives the fixed latency and the inter-burst gap.
            if (!stb_q) begin
              stb_q   <= 1'b1;
              timer_q <= '0;
            end else if (i_wb_ack) begin
              stb_q <= 1'b0;
              if (we_q) begin
                addr_q <= addr_q + ADDR_W'(1);
                if (remain_q == '0) begin
                  state_q <= StIdle;
                end else begin
                  remain_q <= remain_q - CNT_W'(1);
                end
              end else begin
                ser_start_q <= 1'b1;
                ser_raw_q   <= 1'b0;
                ser_word_q  <= i_wb_dat;
                state_q     <= StTxHex;
              end
            end else if (timer_q == TimeoutLast) begin
              stb_q       <= 1'b0;
              err_q       <= 1'b1;
              abort_q     <= 1'b1;
              ser_start_q <= 1'b1;
              ser_raw_q   <= 1'b1;
              ser_word_q  <= DATA_W'(CharBang);
              state_q     <= StTxHex;
            end else begin
              timer_q <= timer_q + 16'd1;
            end
          end
          StTxHex: begin
            if (ser_done) begin
              ser_start_q <= 1'b1;
              ser_raw_q   <= 1'b1;
              ser_word_q  <= DATA_W'(CharEol);
              state_q     <= StTxEol;
            end
          end
          StTxEol: begin
            if (ser_done) begin
              abort_q <= 1'b0;
              if (abort_q) begin
                state_q <= StIdle;
              end else begin
                addr_q <= addr_q + ADDR_W'(1);
                if (remain_q == '0) begin
                  state_q <= StIdle;
                end else begin
                  remain_q <= remain_q - CNT_W'(1);
                  state_q  <= StBus;
                end
              end
            end
          end
        endcase
      end
    end
  end

  hex_tx_serializer #(
    .DATA_W(DATA_W)
  ) u_tx (
    .clk_i       (i_wb_clk),
    .rst_i       (i_wb_rst),
    .start_i     (ser_start_q),
    .raw_i       (ser_raw_q),
    .word_i      (ser_word_q),
    .abort_i     (rx_dot),
    .tx_busy_i   (i_uart_tx_busy),
    .tx_dat_o    (uart_tx_dat),
    .tx_trigger_o(uart_tx_trigger),
    .done_o      (ser_done)
  );

  assign o_wb_dat  = data_q;
  assign o_wb_addr = addr_q;
  assign o_wb_stb  = stb_q;
  assign o_wb_cyc  = stb_q;
  assign o_wb_we   = we_q;
  assign o_reset   = reset_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_uart_hex_wb_bridge.sv
// Directed bench for uart_hex_wb_bridge with a simple Wishbone slave and UART transmitter model.
module tb_uart_hex_wb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ack = 1'b0;
  logic        ack_en;
  logic [7:0]  rd_dat;
  logic [7:0]  wdat;
  logic [23:0] addr;
  logic        stb, cyc, we;
  logic [7:0]  rx_dat;
  logic        rx_stb;
  logic [7:0]  tx_dat;
  logic        trig;
  logic        busy;
  logic        tgt_reset, err;

  logic [7:0]  rd_vals [0:7];
  logic [2:0]  rd_idx = '0;
  int          tx_cnt = 0;

  byte unsigned tx_log[$];
  logic [23:0]  bus_addr[$];
  logic [7:0]   bus_dat[$];
  logic         bus_we[$];
  int           err_cnt = 0, rst_cnt = 0, stb_cyc = 0, viol = 0;
  int           checks = 0, failures = 0;

  always #5 clk = ~clk;

  uart_hex_wb_bridge dut (
    .i_wb_clk            (clk),
    .i_wb_rst            (rst),
    .i_wb_ack            (ack),
    .i_wb_dat            (rd_dat),
    .o_wb_dat            (wdat),
    .o_wb_addr           (addr),
    .o_wb_stb            (stb),
    .o_wb_cyc            (cyc),
    .o_wb_we             (we),
    .uart_rx_dat         (rx_dat),
    .uart_received_strobe(rx_stb),
    .uart_tx_dat         (tx_dat),
    .uart_tx_trigger     (trig),
    .i_uart_tx_busy      (busy),
    .o_reset             (tgt_reset),
    .o_err               (err)
  );

  // Slave acks one cycle after stb is seen; transmitter stays busy 4 cycles per character.
  assign rd_dat = rd_vals[rd_idx];
  assign busy   = (tx_cnt != 0);

  always @(posedge clk) begin
    ack <= rst ? 1'b0 : (stb && !ack && ack_en);
    if (stb && ack && !we) rd_idx <= rd_idx + 3'd1;
    if (rst) tx_cnt <= 0;
    else if (trig) tx_cnt <= 4;
    else if (tx_cnt != 0) tx_cnt <= tx_cnt - 1;
  end

  always @(negedge clk) begin
    if (trig) begin
      tx_log.push_back(tx_dat);
      if (busy) viol++;
    end
    if (stb && ack) begin
      bus_addr.push_back(addr);
      bus_dat.push_back(wdat);
      bus_we.push_back(we);
    end
    if (err) err_cnt++;
    if (tgt_reset) rst_cnt++;
    if (stb) stb_cyc++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] c);
    @(negedge clk);
    rx_dat = c;
    rx_stb = 1'b1;
    @(negedge clk);
    rx_stb = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_tx(input string tag, input int n, input int budget);
    int k = 0;
    while (tx_log.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_eq(tag, tx_log.size(), n);
  endtask

  task automatic wait_bus(input string tag, input int n, input int budget);
    int k = 0;
    while (bus_addr.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    check_eq(tag, bus_addr.size(), n);
  endtask

  task automatic check_tx(input string tag, input int base, input string s);
    for (int i = 0; i < s.len(); i++) begin
      if (base + i < tx_log.size()) check_eq(tag, 32'(tx_log[base + i]), 32'(s[i]));
      else check_eq(tag, 32'hFFFF_FFFF, 32'(s[i]));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int e0, nb, txs, s0, r0, v0;
    ack_en = 1'b1;
    rx_stb = 1'b0;
    rx_dat = '0;
    rd_vals[0] = 8'h3C; rd_vals[1] = 8'hFF; rd_vals[2] = 8'h07; rd_vals[3] = 8'hAB;
    rd_vals[4] = 8'h5E; rd_vals[5] = 8'h00; rd_vals[6] = 8'h00; rd_vals[7] = 8'h00;

    repeat (3) @(negedge clk);
    check_eq("rst_ctrl", 32'({stb, cyc, we, trig, tgt_reset, err}), 32'h0);
    check_eq("rst_addr", 32'(addr), 32'h0);
    check_eq("rst_dat", 32'(wdat), 32'h0);
    check_eq("rst_txdat", 32'(tx_dat), 32'h0);
    rst = 1'b0;

    // Digits before any select land in ADDR.
    send("7");
    check_eq("default_sel", 32'(addr), 32'h7);

    // Single write, fixed latency.
    send_str("a12345");
    send_str("d5A");
    check_eq("addr_load", 32'(addr), 32'h012345);
    check_eq("data_load", 32'(wdat), 32'h5A);
    nb = bus_addr.size();
    @(negedge clk);
    rx_dat = "w";
    rx_stb = 1'b1;
    @(negedge clk);
    rx_stb = 1'b0;
    check_eq("stb_lat1", 32'(stb), 32'h0);
    @(negedge clk);
    check_eq("stb_lat2", 32'({stb, cyc, we}), 32'h7);
    wait_bus("wr_done", nb + 1, 50);
    if (bus_addr.size() > nb) begin
      check_eq("wr_addr", 32'(bus_addr[nb]), 32'h012345);
      check_eq("wr_dat", 32'(bus_dat[nb]), 32'h5A);
      check_eq("wr_we", 32'(bus_we[nb]), 32'h1);
    end
    settle(3);
    check_eq("wr_addr_inc", 32'(addr), 32'h012346);
    check_eq("wr_stb_low", 32'(stb), 32'h0);

    // Unknown character in IDLE flags an error and changes nothing.
    e0 = err_cnt;
    send("x");
    settle(2);
    check_eq("x_idle_err", err_cnt - e0, 1);
    check_eq("x_idle_addr", 32'(addr), 32'h012346);

    // Unknown character during BUS is ignored silently.
    ack_en = 1'b0;
    nb = bus_addr.size();
    send("w");
    settle(4);
    e0 = err_cnt;
    send("x");
    settle(2);
    check_eq("x_bus_err", err_cnt - e0, 0);
    check_eq("x_bus_stb", 32'(stb), 32'h1);
    ack_en = 1'b1;
    wait_bus("x_bus_done", nb + 1, 50);
    settle(3);
    check_eq("x_bus_addr", 32'(addr), 32'h012347);

    // Address wrap.
    send_str("aFFFFFF");
    nb = bus_addr.size();
    send("w");
    wait_bus("wrap_done", nb + 1, 50);
    if (bus_addr.size() > nb) check_eq("wrap_bus_addr", 32'(bus_addr[nb]), 32'hFFFFFF);
    settle(3);
    check_eq("wrap_addr", 32'(addr), 32'h0);

    // Read burst of three.
    send_str("a10");
    send_str("c2");
    txs = tx_log.size();
    nb = bus_addr.size();
    v0 = viol;
    send("r");
    wait_tx("burst_tx", txs + 9, 3000);
    check_tx("burst_chars", txs, "3C\nFF\n07\n");
    check_eq("burst_nbus", bus_addr.size() - nb, 3);
    for (int i = 0; i < 3; i++) begin
      if (nb + i < bus_addr.size()) begin
        check_eq("burst_addr", 32'(bus_addr[nb + i]), 32'h10 + 32'(i));
        check_eq("burst_we", 32'(bus_we[nb + i]), 32'h0);
      end
    end
    check_eq("burst_busy_viol", viol - v0, 0);
    settle(5);
    check_eq("burst_addr_end", 32'(addr), 32'h13);

    // Bus timeout.
    ack_en = 1'b0;
    e0 = err_cnt;
    s0 = stb_cyc;
    txs = tx_log.size();
    send("r");
    wait_tx("to_tx", txs + 2, 1000);
    check_tx("to_chars", txs, "!\n");
    check_eq("to_stb_cycles", stb_cyc - s0, 255);
    check_eq("to_err", err_cnt - e0, 1);
    check_eq("to_addr", 32'(addr), 32'h13);
    ack_en = 1'b1;
    settle(5);
    e0 = err_cnt;
    send("x");
    settle(2);
    check_eq("to_idle", err_cnt - e0, 1);

    // '.' during the hex output of a burst.
    send_str("a20");
    send_str("c3");
    send_str("d11");
    txs = tx_log.size();
    r0 = rst_cnt;
    send("r");
    wait_tx("dot_first", txs + 1, 500);
    @(negedge clk);
    rx_dat = ".";
    rx_stb = 1'b1;
    @(negedge clk);
    rx_stb = 1'b0;
    check_eq("dot_reset", 32'(tgt_reset), 32'h1);
    settle(60);
    check_eq("dot_no_tx", tx_log.size() - txs, 1);
    if (tx_log.size() > txs) check_eq("dot_char", 32'(tx_log[txs]), 32'h41);
    check_eq("dot_rst_cnt", rst_cnt - r0, 1);
    check_eq("dot_addr", 32'(addr), 32'h0);
    check_eq("dot_dat", 32'(wdat), 32'h0);

    // COUNT was cleared as well: a plain read is a single transfer.
    txs = tx_log.size();
    nb = bus_addr.size();
    send("r");
    wait_tx("cnt0_tx", txs + 3, 500);
    settle(20);
    check_tx("cnt0_chars", txs, "5E\n");
    check_eq("cnt0_nbus", bus_addr.size() - nb, 1);
    check_eq("cnt0_addr", 32'(addr), 32'h1);

    // Reset in the middle of a bus cycle.
    ack_en = 1'b0;
    send("w");
    settle(4);
    e0 = err_cnt;
    txs = tx_log.size();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rstbus_stb", 32'({stb, cyc}), 32'h0);
    settle(20);
    check_eq("rstbus_err", err_cnt - e0, 0);
    check_eq("rstbus_tx", tx_log.size() - txs, 0);
    check_eq("rstbus_addr", 32'(addr), 32'h0);
    ack_en = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
